l1_line_adaptor: RTL and testbench

Memory-side responder for the L1 cache's physical-memory port. It accepts one-cycle-granular line requests (read refill or dirty writeback) on the cache side, converts each into a 4-beat burst on the 64-bit memory bus, and returns a single-cycle response with the assembled line. It sits between the L1 cache datapath/control and the physical memory model or arbiter.

---
 rtl/l1_mem_pkg.sv | 18 +
 rtl/l1_line_adaptor.sv | 113 +++++++++++
 tb/tb_l1_line_adaptor.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_pkg.sv
// Shared constants and state encoding for the L1 physical-memory port.
package l1_mem_pkg;

  localparam int unsigned L1_LINE_BITS   = 256;
  localparam int unsigned L1_BURST_BITS  = 64;
  localparam int unsigned L1_ADDR_WIDTH  = 32;
  localparam int unsigned L1_BEATS       = L1_LINE_BITS / L1_BURST_BITS;
  localparam int unsigned L1_CNT_W       = $clog2(L1_BEATS);
  localparam int unsigned L1_OFFSET_BITS = $clog2(L1_LINE_BITS / 8);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } mem_state_t;

endpackage

// File: rtl/l1_line_adaptor.sv
// Converts single-cycle L1 line requests into BEATS-long bursts on the memory bus
// and returns a one-cycle completion with the assembled line.
module l1_line_adaptor
  import l1_mem_pkg::*;
#(
  parameter int unsigned LINE_BITS  = L1_LINE_BITS,
  parameter int unsigned BURST_BITS = L1_BURST_BITS,
  parameter int unsigned ADDR_WIDTH = L1_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic [LINE_BITS-1:0]  line_o,
  output logic                  resp_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [BURST_BITS-1:0] burst_o,
  input  logic [BURST_BITS-1:0] burst_i,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  // A multi-beat line is assumed (NUM_BEATS >= 2) so the counter has width.
  localparam int unsigned NUM_BEATS  = LINE_BITS / BURST_BITS;
  localparam int unsigned CNT_W      = $clog2(NUM_BEATS);
  localparam int unsigned LINE_BYTES = LINE_BITS / 8;

  // Clearing the in-line byte offset yields the line-aligned burst address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             last_beat_c;

  // Beat index arithmetic; the increment wraps to 0 after the last beat.
  assign cnt_inc_c   = cnt + CNT_W'(1);
  assign last_beat_c = (cnt == LAST_BEAT);

  // Transaction FSM; line_o and address_o are the line buffer and address latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      line_o    <= '0;
      address_o <= '0;
      burst_o   <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt    <= '0;
          resp_o <= 1'b0;
          if (write_i) begin
            line_o    <= line_i;
            address_o <= address_i & LINE_MASK;
            burst_o   <= line_i[BURST_BITS-1:0];
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= address_i & LINE_MASK;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (resp_i) begin
            line_o[32'(cnt)*BURST_BITS +: BURST_BITS] <= burst_i;
            cnt <= cnt_inc_c;
            if (last_beat_c) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end

        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt_inc_c;
            if (last_beat_c) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              burst_o <= line_o[32'(cnt_inc_c)*BURST_BITS +: BURST_BITS];
            end
          end
        end

        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          read_o  <= 1'b0;
          write_o <= 1'b0;
          resp_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_line_adaptor.sv
// Directed self-checking bench for l1_line_adaptor.
module tb_l1_line_adaptor;

  logic         clk;
  logic         rst_n;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks;
  int errors;

  l1_line_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address_i (address_i),
    .line_i    (line_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; address_i = '0; line_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    #12;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      errors++; $display("FAIL reset_data line=%h burst=%h addr=%h exp zeros", line_o, burst_o, address_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    logic [63:0]  b [4];
    logic [255:0] exp_line;
    for (int i = 0; i < 4; i++) b[i] = {8{8'hA0 + 8'(i)}};
    exp_line = {b[3], b[2], b[1], b[0]};
    address_i = 32'h1234_567F; read_i = 1;
    tick();
    checks++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      errors++; $display("FAIL rd_start read_o=%b write_o=%b exp 1 0", read_o, write_o);
    end
    checks++;
    if (address_o !== 32'h1234_5660) begin
      errors++; $display("FAIL rd_addr got %h exp 12345660", address_o);
    end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = b[i];
      tick();
      if (i < 3) begin
        checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b1) begin
          errors++; $display("FAIL rd_mid beat%0d resp_o=%b read_o=%b exp 0 1", i, resp_o, read_o);
        end
      end
    end
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      errors++; $display("FAIL rd_done resp_o=%b read_o=%b exp 1 0", resp_o, read_o);
    end
    checks++;
    if (line_o !== exp_line) begin
      errors++; $display("FAIL rd_line got %h exp %h", line_o, exp_line);
    end
    read_i = 0; resp_i = 0;
    tick();
    checks++;
    if (resp_o !== 1'b0 || address_o !== 32'h1234_5660) begin
      errors++; $display("FAIL rd_after resp_o=%b addr=%h exp 0 12345660", resp_o, address_o);
    end
    tick();
    checks++;
    if (read_o !== 1'b0 || line_o !== exp_line) begin
      errors++; $display("FAIL rd_idle read_o=%b line=%h exp 0 %h", read_o, line_o, exp_line);
    end
  endtask

  task automatic test_write_stalls();
    logic [63:0]  d [4];
    logic         pat [7];
    int           exp_idx [7];
    logic [255:0] wline;
    pat = '{1, 0, 1, 0, 0, 1, 1};
    exp_idx = '{0, 1, 1, 2, 2, 2, 3};
    for (int i = 0; i < 4; i++) d[i] = {8{8'hD0 + 8'(i)}};
    wline = {d[3], d[2], d[1], d[0]};
    address_i = 32'h0000_1047; line_i = wline; write_i = 1;
    tick();
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== 32'h0000_1040) begin
      errors++; $display("FAIL wr_start write_o=%b read_o=%b addr=%h exp 1 0 00001040", write_o, read_o, address_o);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (burst_o !== d[exp_idx[k]] || resp_o !== 1'b0 || write_o !== 1'b1) begin
        errors++; $display("FAIL wr_beat cyc%0d burst=%h resp_o=%b write_o=%b exp %h 0 1",
                           k, burst_o, resp_o, write_o, d[exp_idx[k]]);
      end
      resp_i = pat[k];
      tick();
    end
    checks++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      errors++; $display("FAIL wr_done resp_o=%b write_o=%b exp 1 0", resp_o, write_o);
    end
    checks++;
    if (line_o !== wline) begin
      errors++; $display("FAIL wr_line got %h exp %h", line_o, wline);
    end
    write_i = 0; resp_i = 0;
    tick();
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL wr_resp_pulse got %b exp 0", resp_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wline;
    logic [63:0]  r [4];
    int           resp_count;
    int           overlap;
    int           read_rise;
    resp_count = 0; overlap = 0; read_rise = -1;
    wline = {64'h3333_0000_0000_3333, 64'h2222_0000_0000_2222,
             64'h1111_0000_0000_1111, 64'h0000_0000_0000_0ABC};
    for (int i = 0; i < 4; i++) r[i] = 64'hBEEF_0000_0000_0000 | 64'(i);
    address_i = 32'h0000_2000; line_i = wline; write_i = 1; resp_i = 1;
    tick();
    // Writeback: 4 accepted beats, resp_o on the 5th cycle.
    for (int c = 1; c <= 5; c++) begin
      if (read_o && write_o) overlap++;
      if (resp_o) resp_count++;
      if (c < 5) tick();
    end
    checks++;
    if (resp_o !== 1'b1 || resp_count != 1) begin
      errors++; $display("FAIL b2b_wr_resp resp_o=%b count=%0d exp 1 1", resp_o, resp_count);
    end
    // Cache switches to the refill on the edge ending resp_o.
    write_i = 0; read_i = 1; address_i = 32'h0000_3010; resp_i = 0;
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (read_o && write_o) overlap++;
      if (read_o && read_rise < 0) read_rise = c;
    end
    checks++;
    if (read_rise != 2 || address_o !== 32'h0000_3000) begin
      errors++; $display("FAIL b2b_rd_rise cycle=%0d addr=%h exp 2 00003000", read_rise, address_o);
    end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = r[i];
      tick();
      if (read_o && write_o) overlap++;
      if (resp_o) resp_count++;
    end
    checks++;
    if (resp_o !== 1'b1 || resp_count != 2 || overlap != 0) begin
      errors++; $display("FAIL b2b_rd_done resp_o=%b count=%0d overlap=%0d exp 1 2 0", resp_o, resp_count, overlap);
    end
    checks++;
    if (line_o !== {r[3], r[2], r[1], r[0]}) begin
      errors++; $display("FAIL b2b_line got %h exp %h", line_o, {r[3], r[2], r[1], r[0]});
    end
    read_i = 0; resp_i = 0;
    tick();
  endtask

  task automatic test_both_requests();
    logic [255:0] wline;
    wline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    address_i = 32'h0000_4000; line_i = wline; read_i = 1; write_i = 1;
    tick();
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== 64'h1111_1111_1111_1111) begin
      errors++; $display("FAIL both_prio write_o=%b read_o=%b burst=%h exp 1 0 1111111111111111", write_o, read_o, burst_o);
    end
    resp_i = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== wline) begin
      errors++; $display("FAIL both_done resp_o=%b read_o=%b line=%h exp 1 0 %h", resp_o, read_o, line_o, wline);
    end
    read_i = 0; write_i = 0; resp_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0]  n [4];
    for (int i = 0; i < 4; i++) n[i] = 64'h5A5A_0000_0000_0000 | 64'(i + 16);
    address_i = 32'h0000_5020; read_i = 1;
    tick();
    resp_i = 1; burst_i = 64'hDEAD_DEAD_DEAD_0001;
    tick();
    burst_i = 64'hDEAD_DEAD_DEAD_0002;
    tick();
    // Mid-cycle during beat 2: outputs must drop without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_ctrl got %b exp 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== '0 || address_o !== '0) begin
      errors++; $display("FAIL rst_mid_data line=%h addr=%h exp zeros", line_o, address_o);
    end
    read_i = 0; resp_i = 0;
    #2 rst_n = 1'b1;
    tick();
    address_i = 32'h0000_6000; read_i = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = n[i];
      tick();
    end
    checks++;
    if (resp_o !== 1'b1 || line_o !== {n[3], n[2], n[1], n[0]} || address_o !== 32'h0000_6000) begin
      errors++; $display("FAIL rst_recover resp_o=%b line=%h addr=%h exp 1 %h 00006000",
                         resp_o, line_o, address_o, {n[3], n[2], n[1], n[0]});
    end
    read_i = 0; resp_i = 0;
    tick();
  endtask

  task automatic test_spurious_resp();
    logic [255:0] held;
    logic [63:0]  s [4];
    int           bad;
    held = line_o;
    bad = 0;
    resp_i = 1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (read_o || write_o || resp_o) bad++;
    end
    checks++;
    if (bad != 0 || line_o !== held) begin
      errors++; $display("FAIL spur_idle bad=%0d line=%h exp 0 %h", bad, line_o, held);
    end
    // resp_i stays high through DONE and the following IDLE cycles.
    for (int i = 0; i < 4; i++) s[i] = 64'hC0DE_0000_0000_0000 | 64'(i + 32);
    address_i = 32'h0000_7000; read_i = 1; resp_i = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = s[i];
      tick();
    end
    checks++;
    if (resp_o !== 1'b1) begin
      errors++; $display("FAIL spur_done_resp got %b exp 1", resp_o);
    end
    read_i = 0; burst_i = 64'h0BAD_0BAD_0BAD_0BAD;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (read_o || write_o || resp_o) bad++;
    end
    checks++;
    if (bad != 0 || line_o !== {s[3], s[2], s[1], s[0]}) begin
      errors++; $display("FAIL spur_after_done bad=%0d line=%h exp 0 %h", bad, line_o, {s[3], s[2], s[1], s[0]});
    end
    resp_i = 0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_write_stalls();
    test_back_to_back();
    test_both_requests();
    test_reset_mid_burst();
    test_spurious_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
